tone_pitch_detector: RTL and testbench

//  Receive-side counterpart of the note/waveform generators: consumes the

---
 rtl/tone_pitch_detector.sv | 190 +++++++++++++++++++
 tb/tb_tone_pitch_detector.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_pitch_detector.sv
// rtl/tone_pitch_detector.sv - hysteresis zero-crossing period detector; TONE_PEAK_EN adds peak_out
module tone_pitch_detector #(
  parameter int SAMPLE_W   = 32,
  parameter int HYST       = 20000000,
  parameter int PERIOD_W   = 16,
  parameter int MIN_PERIOD = 8,
  parameter int MAX_PERIOD = 4000,
  parameter int AVG_LOG2   = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  output logic [PERIOD_W-1:0]        period_out,
  output logic                       period_valid,
  output logic                       note_present
`ifdef TONE_PEAK_EN
  ,
  output logic [SAMPLE_W-1:0]        peak_out
`endif
);

  localparam int ACC_W  = PERIOD_W + AVG_LOG2;
  localparam int NPER_W = AVG_LOG2 + 1;
  localparam logic signed [SAMPLE_W-1:0] HYST_POS  = SAMPLE_W'(HYST);
  localparam logic signed [SAMPLE_W-1:0] HYST_NEG  = SAMPLE_W'(-HYST);
  localparam logic [PERIOD_W-1:0]        MIN_P     = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0]        MAX_P     = PERIOD_W'(MAX_PERIOD);
  localparam logic [NPER_W-1:0]          NPER_LAST = NPER_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {SYNC_LOW, SYNC_HIGH, HIGH, LOW} state_t;

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] p;
  logic [PERIOD_W-1:0] pout_d;
  logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
  logic [NPER_W-1:0]   nper_q, nper_d;
  logic                note_d, pvalid_d;
  logic                is_low, is_high, p_ok, p_over;
  logic                clear;

  // Crossing thresholds (inclusive) and the candidate period if this sample is an edge
  assign is_low  = (sample_in <= HYST_NEG);
  assign is_high = (sample_in >= HYST_POS);
  assign p       = cnt_q + PERIOD_W'(1);
  assign p_ok    = (p >= MIN_P) && (p <= MAX_P);
  assign p_over  = (p > MAX_P);
  assign acc_sum = acc_q + ACC_W'(p);

`ifdef TONE_PEAK_EN
  localparam logic [SAMPLE_W-1:0] ABS_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  logic [SAMPLE_W-1:0] abs_s, trk_q, trk_d, trk_upd, peak_d;

  // Magnitude of the sample; the most negative value saturates to the largest positive one
  always_comb begin
    abs_s = sample_in;
    if (sample_in[SAMPLE_W-1]) begin
      if (sample_in[SAMPLE_W-2:0] == '0) abs_s = ABS_MAX;
      else                               abs_s = -sample_in;
    end
  end

  assign trk_upd = (abs_s > trk_q) ? abs_s : trk_q;
`endif

  // State register for the crossing tracker
  always_ff @(posedge clock) begin
    if (reset) state_q <= SYNC_LOW;
    else       state_q <= state_d;
  end

  // Next state and datapath decisions, acting only on accepted samples
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    nper_d   = nper_q;
    note_d   = note_present;
    pout_d   = period_out;
    pvalid_d = 1'b0;
    clear    = 1'b0;
`ifdef TONE_PEAK_EN
    trk_d    = trk_q;
    peak_d   = peak_out;
`endif
    if (!enable) begin
      clear = 1'b1;
    end else if (sample_valid) begin
`ifdef TONE_PEAK_EN
      trk_d = trk_upd;
`endif
      case (state_q)
        SYNC_LOW: begin
          if (is_low) state_d = SYNC_HIGH;
        end
        SYNC_HIGH: begin
          // first rising crossing only starts the count
          if (is_high) begin
            state_d = HIGH;
            cnt_d   = '0;
          end
        end
        HIGH: begin
          if (p_over) begin
            clear = 1'b1;
          end else begin
            cnt_d = p;
            if (is_low) state_d = LOW;
          end
        end
        LOW: begin
          if (is_high) begin
            // measured edge; an out-of-range period restarts as a fresh first edge
            state_d = HIGH;
            cnt_d   = '0;
            if (p_ok) begin
              if (nper_q == NPER_LAST) begin
                pout_d   = PERIOD_W'(acc_sum >> AVG_LOG2);
                pvalid_d = 1'b1;
                note_d   = 1'b1;
                acc_d    = '0;
                nper_d   = '0;
`ifdef TONE_PEAK_EN
                peak_d   = trk_upd;
                trk_d    = '0;
`endif
              end else begin
                acc_d  = acc_sum;
                nper_d = nper_q + NPER_W'(1);
              end
            end else begin
              acc_d  = '0;
              nper_d = '0;
              note_d = 1'b0;
`ifdef TONE_PEAK_EN
              trk_d  = '0;
`endif
            end
          end else if (p_over) begin
            clear = 1'b1;
          end else begin
            cnt_d = p;
          end
        end
        default: state_d = SYNC_LOW;
      endcase
    end
    // timeout and disable both drop lock but keep the last reported period
    if (clear) begin
      state_d = SYNC_LOW;
      cnt_d   = '0;
      acc_d   = '0;
      nper_d  = '0;
      note_d  = 1'b0;
`ifdef TONE_PEAK_EN
      trk_d   = '0;
`endif
    end
  end

  // Datapath and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= '0;
      acc_q        <= '0;
      nper_q       <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      note_present <= 1'b0;
`ifdef TONE_PEAK_EN
      trk_q        <= '0;
      peak_out     <= '0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      nper_q       <= nper_d;
      period_out   <= pout_d;
      period_valid <= pvalid_d;
      note_present <= note_d;
`ifdef TONE_PEAK_EN
      trk_q        <= trk_d;
      peak_out     <= peak_d;
`endif
    end
  end

endmodule

// File: tb/tb_tone_pitch_detector.sv
// tb/tb_tone_pitch_detector.sv - self-checking bench for tone_pitch_detector
module tb_tone_pitch_detector;

  localparam int HYST  = 20000000;
  localparam int MIN_P = 8;
  localparam int MAX_P = 4000;
  localparam int NWIN  = 4;
  localparam int AMP   = 150000000;
  localparam int MOST_NEG = -2147483647 - 1;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic               sample_valid = 1'b0;
  logic signed [31:0] sample_in = '0;
  logic [15:0]        period_out;
  logic               period_valid;
  logic               note_present;
`ifdef TONE_PEAK_EN
  logic [31:0]        peak_out;
`endif

  tone_pitch_detector dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .sample_valid(sample_valid),
    .sample_in(sample_in),
    .period_out(period_out),
    .period_valid(period_valid),
    .note_present(note_present)
`ifdef TONE_PEAK_EN
    ,
    .peak_out(peak_out)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int pulses = 0;

  // reference model: counts accepted samples and measures distances between rising crossings
  int     m_mode;
  int     m_n;
  int     m_edge;
  bit     m_low_seen;
  int     m_q[$];
  int     m_pout;
  bit     m_note;
  bit     m_pv;
  longint m_trk;
  longint m_peak;

  typedef struct {
    int hi;
    int lo;
    int amp;
    int cycles;
    int vpct;
    int exp_pulses;
    int exp_period;
    bit exp_note;
  } row_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic longint absval(input int s);
    if (s == MOST_NEG) return 64'd2147483647;
    return (s < 0) ? -longint'(s) : longint'(s);
  endfunction

  task automatic model_clear();
    m_mode = 0;
    m_q.delete();
    m_note = 1'b0;
    m_trk = 0;
  endtask

  task automatic model_step(input bit rst, input bit en, input bit v, input int s);
    int p;
    int sum;
    m_pv = 1'b0;
    if (rst) begin
      model_clear();
      m_n = 0;
      m_edge = 0;
      m_pout = 0;
      m_peak = 0;
    end else if (!en) begin
      model_clear();
    end else if (v) begin
      m_n++;
      if (absval(s) > m_trk) m_trk = absval(s);
      if (m_mode == 0) begin
        if (s <= -HYST) m_mode = 1;
      end else if (m_mode == 1) begin
        if (s >= HYST) begin
          m_mode = 2;
          m_edge = m_n;
          m_low_seen = 1'b0;
        end
      end else if (m_low_seen && s >= HYST) begin
        p = m_n - m_edge;
        m_edge = m_n;
        m_low_seen = 1'b0;
        if (p >= MIN_P && p <= MAX_P) begin
          m_q.push_back(p);
          if (m_q.size() == NWIN) begin
            sum = 0;
            foreach (m_q[k]) sum += m_q[k];
            m_pout = sum / NWIN;
            m_pv = 1'b1;
            m_note = 1'b1;
            m_peak = m_trk;
            m_trk = 0;
            m_q.delete();
          end
        end else begin
          m_q.delete();
          m_note = 1'b0;
          m_trk = 0;
        end
      end else if (m_n - m_edge > MAX_P) begin
        model_clear();
      end else if (s <= -HYST) begin
        m_low_seen = 1'b1;
      end
    end
  endtask

  // one clock: drive at the falling edge, check just after the rising edge
  task automatic cyc(input bit rst, input bit en, input bit v, input int s);
    reset = rst;
    enable = en;
    sample_valid = v;
    sample_in = s;
    model_step(rst, en, v, s);
    @(posedge clock);
    #1;
    chk("period_valid", period_valid, m_pv);
    chk("period_out", period_out, m_pout);
    chk("note_present", note_present, m_note);
`ifdef TONE_PEAK_EN
    chk("peak_out", peak_out, m_peak);
`endif
    if (period_valid) pulses++;
    @(negedge clock);
  endtask

  // deliver one accepted sample, inserting random idle cycles carrying junk data
  task automatic put(input int s, input int vpct);
    bit v;
    do begin
      v = ($urandom_range(99) < vpct);
      cyc(1'b0, 1'b1, v, v ? s : int'($urandom));
    end while (!v);
  endtask

  task automatic do_reset();
    repeat (3) cyc(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), int'($urandom));
    pulses = 0;
  endtask

  // arming low run, then cycles of high/low, then one closing high sample
  task automatic square(input int hi, input int lo, input int hv, input int lv,
                        input int cycles, input int vpct);
    repeat (lo) put(lv, vpct);
    repeat (cycles) begin
      repeat (hi) put(hv, vpct);
      repeat (lo) put(lv, vpct);
    end
    put(hv, vpct);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t rows[9];
    rows[0] = '{50,   50,   AMP,      8,  100, 2, 100,  1'b1};
    rows[1] = '{100,  100,  AMP,      6,  70,  1, 200,  1'b1};
    rows[2] = '{4,    4,    AMP,      8,  100, 2, 8,    1'b1};
    rows[3] = '{3,    3,    AMP,      12, 100, 0, 0,    1'b0};
    rows[4] = '{2000, 2000, AMP,      4,  100, 1, 4000, 1'b1};
    rows[5] = '{2001, 2000, AMP,      3,  100, 0, 0,    1'b0};
    rows[6] = '{50,   50,   HYST,     4,  100, 1, 100,  1'b1};
    rows[7] = '{50,   50,   HYST - 1, 4,  100, 0, 0,    1'b0};
    rows[8] = '{30,   71,   AMP,      4,  100, 1, 101,  1'b1};

    @(negedge clock);

    // reset state
    do_reset();
    chk("reset_period_out", period_out, 0);
    chk("reset_note", note_present, 0);
    chk("reset_valid", period_valid, 0);

    // square-wave table
    for (int i = 0; i < 9; i++) begin
      do_reset();
      square(rows[i].hi, rows[i].lo, rows[i].amp, -rows[i].amp, rows[i].cycles, rows[i].vpct);
      cyc(1'b0, 1'b1, 1'b0, 0);
      chk($sformatf("row%0d_pulses", i), pulses, rows[i].exp_pulses);
      chk($sformatf("row%0d_period", i), period_out, rows[i].exp_period);
      chk($sformatf("row%0d_note", i), note_present, rows[i].exp_note);
    end

    // sub-threshold noise never arms
    do_reset();
    repeat (10000) put(int'($urandom_range(20000000)) - 10000000, 100);
    chk("noise_pulses", pulses, 0);
    chk("noise_note", note_present, 0);

    // too-short period, then a valid 200-sample tone
    do_reset();
    square(3, 3, AMP, -AMP, 10, 100);
    chk("short_pulses", pulses, 0);
    repeat (99) put(AMP, 100);
    repeat (100) put(-AMP, 100);
    repeat (3) begin
      repeat (100) put(AMP, 100);
      repeat (100) put(-AMP, 100);
    end
    put(AMP, 100);
    chk("switch_pulses", pulses, 1);
    chk("switch_period", period_out, 200);

    // timeout boundary: lock survives 4000 edgeless samples, drops on the next
    do_reset();
    square(50, 50, AMP, -AMP, 4, 100);
    chk("lock_note", note_present, 1);
    repeat (4000) put(0, 100);
    chk("timeout_note_held", note_present, 1);
    put(0, 100);
    chk("timeout_note_drop", note_present, 0);
    chk("timeout_period_hold", period_out, 100);

    // reset mid-window discards the partial accumulation
    do_reset();
    square(50, 50, AMP, -AMP, 2, 100);
    do_reset();
    square(50, 50, AMP, -AMP, 3, 100);
    chk("resync_3_pulses", pulses, 0);
    repeat (50) put(AMP, 100);
    repeat (50) put(-AMP, 100);
    put(AMP, 100);
    chk("resync_4_pulses", pulses, 1);
    chk("resync_period", period_out, 100);
`ifdef TONE_PEAK_EN
    chk("peak_square", peak_out, 150000000);
`endif
    do_reset();
    square(50, 50, AMP, MOST_NEG, 4, 100);
    chk("mostneg_period", period_out, 100);
`ifdef TONE_PEAK_EN
    chk("peak_saturate", peak_out, 64'd2147483647);
`endif

    // enable low clears lock but holds the period
    do_reset();
    square(50, 50, AMP, -AMP, 4, 100);
    cyc(1'b0, 1'b0, 1'b1, AMP);
    chk("disable_note", note_present, 0);
    chk("disable_period", period_out, 100);
    pulses = 0;
    square(50, 50, AMP, -AMP, 4, 70);
    chk("reenable_pulses", pulses, 1);

    // randomized bursts against the model
    do_reset();
    for (int b = 0; b < 60; b++) begin
      int hi;
      int lo;
      int k;
      int amp;
      int vp;
      int sel;
      hi  = int'($urandom_range(60, 1));
      lo  = int'($urandom_range(60, 1));
      k   = int'($urandom_range(4, 1));
      vp  = int'($urandom_range(100, 50));
      sel = int'($urandom_range(4));
      case (sel)
        0:       amp = HYST;
        1:       amp = AMP;
        2:       amp = int'($urandom_range(32'h7fffffff, HYST));
        3:       amp = HYST - 1;
        default: amp = 0;
      endcase
      if ($urandom_range(9) == 0) cyc(1'b0, 1'b0, 1'b1, int'($urandom));
      if (sel == 4) begin
        repeat (50) put(int'($urandom), vp);
      end else begin
        repeat (k) begin
          repeat (hi) put(amp, vp);
          repeat (lo) put(-amp, vp);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
